sync_fifo_v2: RTL and testbench
===============================

SYNC_FIFO_V2 -- requirements
Module: sync_fifo_v2

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; SHALL accept any integer >= 2, power of two not required.
REQ-002 Parameter WIDTH, default 8, data bits per entry.
REQ-003 Parameter RD_LATENCY, default 0, read mode: 0 = show-ahead (head visible), 1 = registered read (data one cycle after pop).
REQ-004 Local CNT_W = $clog2(DEPTH+1); PTR_W = $clog2(DEPTH).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rstn  input  1  reset, synchronous and active-low.
REQ-007 flush  input  1  synchronous empty request.
REQ-008 wren  input  1  write request.
REQ-009 wrdata  input  WIDTH  write data.
REQ-010 rden  input  1  read/pop request.
REQ-011 af_thresh  input  CNT_W  almost-full threshold.
REQ-012 ae_thresh  input  CNT_W  almost-empty threshold.
REQ-013 err_clr  input  1  clears sticky error flags.
REQ-014 rddata  output  WIDTH  read data.
REQ-015 rdvalid  output  1  RD_LATENCY=1: rddata updated this cycle; RD_LATENCY=0: equals !empty.
REQ-016 count  output  CNT_W  occupied entries.
REQ-017 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-018 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-019 Write accepted (wr_acc) iff wren && !full && !flush; entry stored at wr_ptr, wr_ptr advances.
REQ-020 Read accepted (rd_acc) iff rden && !empty && !flush; rd_ptr advances.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 (modulo DEPTH, including non-power-of-two DEPTH).
REQ-022 count next = count + wr_acc - rd_acc; simultaneous accepted read and write leaves count unchanged.
REQ-023 Full uses registered state: write while full is rejected even if a read is accepted the same cycle.
REQ-024 Empty uses registered state: read while empty is rejected even if a write is accepted the same cycle; that write is still accepted.
REQ-025 full = (count == DEPTH); empty = (count == 0); both combinational from count.
REQ-026 almost_full = (count >= af_thresh); almost_empty = (count <= ae_thresh); thresholds sampled live, unsigned compare.
REQ-027 overflow SHALL set the cycle after wren && full && !flush; underflow SHALL set the cycle after rden && empty && !flush.
REQ-028 Sticky flags hold until err_clr or reset; on the same cycle, a set condition wins over err_clr.
REQ-029 flush: next cycle pointers = 0, count = 0, rdvalid = 0; wren/rden ignored that cycle; sticky flags and memory contents unaffected.
REQ-030 RD_LATENCY=0: rddata = mem[rd_ptr] when !empty, 0 when empty; pop takes effect at the clock edge.
REQ-031 RD_LATENCY=1: on rd_acc, rddata <= mem[rd_ptr] and rdvalid <= 1 next cycle; otherwise rdvalid <= 0 and rddata holds.
REQ-032 Memory array SHALL NOT be reset; only control state and outputs are reset.

Reset
REQ-033 When rstn = 0 at a rising edge: pointers, count, overflow, underflow, rdvalid and registered rddata = 0; hence empty = 1, full = 0.
REQ-034 Reset SHALL take priority over flush, wren, rden and err_clr; reset mid-burst discards all stored entries.
REQ-035 No output SHALL change asynchronously with rstn.

Verification
REQ-036 DEPTH=16, RD_LATENCY=0: write 0x00..0x0F -> full=1, count=16; 17th write -> overflow=1, count stays 16; read 16 -> data 0x00..0x0F in order, empty=1.
REQ-037 DEPTH=5: 3 writes, then 20 cycles of simultaneous write and read -> count holds 3, data in order across pointer wrap 4->0.
REQ-038 Empty with wren=1 and rden=1 in one cycle -> underflow=1 next cycle, count=1, written value readable next.
REQ-039 RD_LATENCY=1: write 0xA5, pulse rden -> rddata=0xA5 with rdvalid=1 one cycle later; rdvalid=0 the following cycle.
REQ-040 count=10, af_thresh=10, ae_thresh=2 -> almost_full=1; flush -> count=0, empty=1, almost_empty=1, overflow unchanged; err_clr -> overflow=0.
REQ-041 Assert rstn=0 mid-burst at count=7 -> at next edge count=0, empty=1, flags cleared; no change between edges.

Source files
------------

// File: rtl/sync_fifo_v2_if.sv
// sync_fifo_v2_if: FIFO control, data and status bundle shared by producer/consumer and FIFO
interface sync_fifo_v2_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic             flush;
  logic             wren;
  logic [WIDTH-1:0] wrdata;
  logic             rden;
  logic [CNT_W-1:0] af_thresh;
  logic [CNT_W-1:0] ae_thresh;
  logic             err_clr;
  logic [WIDTH-1:0] rddata;
  logic             rdvalid;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;
  modport master (
    output flush, wren, wrdata, rden, af_thresh, ae_thresh, err_clr,
    input  rddata, rdvalid, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input  flush, wren, wrdata, rden, af_thresh, ae_thresh, err_clr,
    output rddata, rdvalid, count, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: synchronous FIFO with any depth, show-ahead or registered read, thresholds and sticky errors
module sync_fifo_v2 #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 8,
  parameter int RD_LATENCY = 0
) (
  input logic           clk,
  input logic           rstn,
  sync_fifo_v2_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, rdvalid_q, rdvalid_d;
  logic [WIDTH-1:0] rddata_q, rddata_d;
  logic             full, empty, wr_acc, rd_acc;
  // Status comes from the registered count only, so a same-cycle pop never frees room for a push
  assign full   = count_q == CNT_W'(DEPTH);
  assign empty  = count_q == '0;
  assign wr_acc = bus.wren && !full && !bus.flush;
  assign rd_acc = bus.rden && !empty && !bus.flush;
  // Next-state: pointer wrap at DEPTH-1 handles non-power-of-two depths; error set beats clear
  always_comb begin
    wr_ptr_d  = bus.flush ? '0 : !wr_acc ? wr_ptr_q : (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d  = bus.flush ? '0 : !rd_acc ? rd_ptr_q : (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d   = bus.flush ? '0 : count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    ovf_d     = (bus.wren && full && !bus.flush) || (ovf_q && !bus.err_clr);
    unf_d     = (bus.rden && empty && !bus.flush) || (unf_q && !bus.err_clr);
    rdvalid_d = (RD_LATENCY != 0) && rd_acc;
    rddata_d  = ((RD_LATENCY != 0) && rd_acc) ? mem_q[rd_ptr_q] : rddata_q;
  end
  // Control state and registered read port; reset overrides every request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rdvalid_q <= 1'b0;
      rddata_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      rdvalid_q <= rdvalid_d;
      rddata_q  <= rddata_d;
    end
  end
  // Storage array is left unreset; flush and reset only move the control state
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) mem_q[wr_ptr_q] <= bus.wrdata;
  end
  assign bus.rddata       = (RD_LATENCY != 0) ? rddata_q : (empty ? '0 : mem_q[rd_ptr_q]);
  assign bus.rdvalid      = (RD_LATENCY != 0) ? rdvalid_q : !empty;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = count_q >= bus.af_thresh;
  assign bus.almost_empty = count_q <= bus.ae_thresh;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: drives a 16-deep show-ahead FIFO and a 5-deep registered-read FIFO in lockstep against a queue model
module tb_sync_fifo_v2;
  logic clk = 1'b0;
  logic rstn, flush, wren, rden, err_clr;
  logic [7:0] wrdata;
  logic [4:0] afa, aea;
  logic [2:0] afb, aeb;
  int total = 0, bad = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  sync_fifo_v2_if #(.DEPTH(16), .WIDTH(8)) ia ();
  sync_fifo_v2_if #(.DEPTH(5), .WIDTH(8)) ib ();
  assign ia.flush = flush;   assign ib.flush = flush;
  assign ia.wren = wren;     assign ib.wren = wren;
  assign ia.wrdata = wrdata; assign ib.wrdata = wrdata;
  assign ia.rden = rden;     assign ib.rden = rden;
  assign ia.err_clr = err_clr; assign ib.err_clr = err_clr;
  assign ia.af_thresh = afa; assign ia.ae_thresh = aea;
  assign ib.af_thresh = afb; assign ib.ae_thresh = aeb;
  sync_fifo_v2 #(.DEPTH(16), .WIDTH(8), .RD_LATENCY(0)) dut_a (.clk(clk), .rstn(rstn), .bus(ia.slave));
  sync_fifo_v2 #(.DEPTH(5), .WIDTH(8), .RD_LATENCY(1)) dut_b (.clk(clk), .rstn(rstn), .bus(ib.slave));
  logic [7:0] mq [2][$];
  bit m_ovf [2], m_unf [2], m_rv [2];
  logic [7:0] m_rd [2];
  int dep [2] = '{16, 5};
  int rl [2] = '{0, 1};
  initial begin
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        int n;
        bit f, e;
        logic [7:0] v;
        n = mq[k].size();
        f = (n == dep[k]);
        e = (n == 0);
        if (!rstn) begin
          mq[k].delete();
          m_ovf[k] = 0; m_unf[k] = 0; m_rv[k] = 0; m_rd[k] = 8'h00;
        end else begin
          m_ovf[k] = (wren && f && !flush) || (m_ovf[k] && !err_clr);
          m_unf[k] = (rden && e && !flush) || (m_unf[k] && !err_clr);
          m_rv[k] = 0;
          if (flush) mq[k].delete();
          else begin
            if (rden && !e) begin
              v = mq[k].pop_front();
              if (rl[k] == 1) begin m_rd[k] = v; m_rv[k] = 1; end
            end
            if (wren && !f) mq[k].push_back(wrdata);
          end
        end
      end
    end
  end
  function automatic logic [31:0] pk(int c, bit f, bit e, bit af, bit ae, bit ov, bit un, bit rv, logic [7:0] d);
    logic [7:0] c8;
    c8 = c[7:0];
    return {8'h00, c8, f, e, af, ae, ov, un, rv, 1'b0, d};
  endfunction
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        int n;
        logic [31:0] ex, ac;
        logic [7:0] d;
        n = mq[k].size();
        d = (rl[k] == 1) ? m_rd[k] : (n != 0 ? mq[k][0] : 8'h00);
        ex = pk(n, n == dep[k], n == 0, n >= int'(k == 0 ? afa : 5'(afb)), n <= int'(k == 0 ? aea : 5'(aeb)),
                m_ovf[k], m_unf[k], (rl[k] == 1) ? m_rv[k] : (n != 0), d);
        ac = (k == 0) ? pk(int'(ia.count), ia.full, ia.empty, ia.almost_full, ia.almost_empty, ia.overflow, ia.underflow, ia.rdvalid, ia.rddata)
                      : pk(int'(ib.count), ib.full, ib.empty, ib.almost_full, ib.almost_empty, ib.overflow, ib.underflow, ib.rdvalid, ib.rddata);
        total++;
        if (ac !== ex) begin
          bad++;
          $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", k, $time, ac, ex);
        end
      end
    end
  end
  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask
  task automatic cyc(bit w, logic [7:0] d, bit r, bit f = 0, bit c = 0);
    wren = w; wrdata = d; rden = r; flush = f; err_clr = c;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rstn = 0; flush = 0; wren = 0; rden = 0; err_clr = 0; wrdata = 0;
    afa = 12; aea = 3; afb = 4; aeb = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;
    rstn = 1;
    chk("rst_empty_a", int'(ia.empty), 1);
    chk("rst_count_a", int'(ia.count), 0);
    chk("rst_rdvalid_b", int'(ib.rdvalid), 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
    chk("fill_count_a", int'(ia.count), 16);
    chk("fill_full_a", int'(ia.full), 1);
    chk("fill_count_b", int'(ib.count), 5);
    cyc(1, 8'h10, 0);
    chk("ovf_a", int'(ia.overflow), 1);
    chk("ovf_count_a", int'(ia.count), 16);
    chk("head_a", int'(ia.rddata), 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1);
    chk("drain_empty_a", int'(ia.empty), 1);
    chk("drain_unf_a", int'(ia.underflow), 0);
    chk("drain_unf_b", int'(ib.underflow), 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'h33 + i), 1);
    chk("wrap_count_b", int'(ib.count), 3);
    chk("wrap_data_b", int'(ib.rddata), 8'h43);
    chk("wrap_valid_b", int'(ib.rdvalid), 1);
    chk("wrap_head_a", int'(ia.rddata), 8'h44);
    cyc(1, 8'hEE, 0, 1);
    chk("flush_wr_ignored_a", int'(ia.count), 0);
    cyc(1, 8'h77, 1);
    chk("wr_rd_empty_unf_a", int'(ia.underflow), 1);
    chk("wr_rd_empty_count_a", int'(ia.count), 1);
    chk("wr_rd_empty_data_a", int'(ia.rddata), 8'h77);
    chk("wr_rd_empty_valid_b", int'(ib.rdvalid), 0);
    cyc(0, 0, 1);
    chk("pop77_b", int'(ib.rddata), 8'h77);
    cyc(1, 8'hA5, 0);
    cyc(0, 0, 1);
    chk("rl1_data_b", int'(ib.rddata), 8'hA5);
    chk("rl1_valid_b", int'(ib.rdvalid), 1);
    cyc(0, 0, 0);
    chk("rl1_valid_drop_b", int'(ib.rdvalid), 0);
    chk("rl1_hold_b", int'(ib.rddata), 8'hA5);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'h50 + i), 0);
    afa = 10; aea = 2;
    #1;
    chk("af_at_thresh_a", int'(ia.almost_full), 1);
    chk("ae_above_a", int'(ia.almost_empty), 0);
    afa = 11;
    #1;
    chk("af_below_a", int'(ia.almost_full), 0);
    afa = 10;
    cyc(0, 0, 0, 1);
    chk("flush_count_a", int'(ia.count), 0);
    chk("flush_ae_a", int'(ia.almost_empty), 1);
    chk("flush_keeps_ovf_a", int'(ia.overflow), 1);
    cyc(0, 0, 0, 0, 1);
    chk("errclr_ovf_a", int'(ia.overflow), 0);
    chk("errclr_unf_b", int'(ib.underflow), 0);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0);
    cyc(1, 8'h99, 0, 0, 1);
    chk("set_beats_clr_b", int'(ib.overflow), 1);
    chk("no_ovf_a", int'(ia.overflow), 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'h70 + i), 0);
    rstn = 0;
    #2;
    chk("rst_no_async_count_a", int'(ia.count), 7);
    chk("rst_no_async_ovf_b", int'(ib.overflow), 1);
    cyc(1, 8'h11, 1, 1, 1);
    chk("rst_count_a2", int'(ia.count), 0);
    chk("rst_empty_a2", int'(ia.empty), 1);
    chk("rst_ovf_b2", int'(ib.overflow), 0);
    rstn = 1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
